// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
// FETCH_FAULT_EN (optional) enables the instruction-space range check in the top level.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
        logic        fault;
    } fq_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SQUASH
    } fetch_state_t;

    localparam logic [31:0] INSTR_LIMIT = 32'h0000_6000;
    localparam logic [31:0] NOP         = 32'h0000_0013;

    function automatic logic pc_out_of_range(input logic [31:0] pc);
        return (pc >= INSTR_LIMIT);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr, fault} entries; flush wins over push and pop.
// Head entry is presented directly from storage; pointers and count are the only reset state.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  fq_entry_t     i_din,
    output fq_entry_t     o_dout,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    fq_entry_t       r_mem [DEPTH];
    logic [AW-1:0]   r_wr;
    logic [AW-1:0]   r_rd;
    logic [CW-1:0]   r_cnt;
    logic            w_push;
    logic            w_pop;

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;
    assign o_dout  = r_mem[r_rd];

    assign w_push = i_push & ~o_full & ~i_flush;
    assign w_pop  = i_pop & ~o_empty & ~i_flush;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr] <= i_din;
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front end: owns the fetch PC, issues held read requests to the memory wrapper and
// buffers results in fetch_fifo. Optional macro FETCH_FAULT_EN adds out-of-range fault entries.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        BR_TAKEN,
    input  logic [31:0] BR_PC,
    input  logic        IF_READY,
    output logic        IF_VALID,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_IR,
`ifdef FETCH_FAULT_EN
    output logic        IF_FAULT,
`endif
    output logic        MEM_RDEN1,
    output logic [13:0] MEM_ADDR1,
    input  logic [31:0] MEM_DOUT1,
    input  logic        memValid1
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  r_state;
    fetch_state_t  w_state_nxt;
    logic [31:0]   r_pc;
    logic [31:0]   w_pc_nxt;
    logic [13:0]   r_sq_addr;
    logic          w_sq_load;
    logic          r_halt;
    logic          w_halt_nxt;
    logic          w_out_of_range;
    logic          w_push;
    logic          w_pop;
    logic          w_flush;
    logic          w_full;
    logic          w_empty;
    logic          w_last_slot;
    logic [CW-1:0] w_count;
    fq_entry_t     w_entry;
    fq_entry_t     w_head;

`ifdef FETCH_FAULT_EN
    assign w_out_of_range = pc_out_of_range(r_pc);
`else
    assign w_out_of_range = 1'b0;
`endif

    assign IF_VALID    = ~w_empty;
    assign IF_PC       = w_empty ? 32'h0 : w_head.pc;
    assign IF_IR       = w_empty ? 32'h0 : w_head.ir;
`ifdef FETCH_FAULT_EN
    assign IF_FAULT    = ~w_empty & w_head.fault;
`else
    logic w_unused_fault;
    assign w_unused_fault = w_head.fault;
`endif

    // A squashed request must keep presenting the address it was launched with.
    assign MEM_ADDR1   = (r_state == SQUASH) ? r_sq_addr : r_pc[15:2];
    assign w_last_slot = (w_count == CW'(DEPTH - 1)) && !w_pop;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_halt_nxt  = r_halt;
        w_push      = 1'b0;
        w_sq_load   = 1'b0;
        MEM_RDEN1   = 1'b0;
        w_entry     = '{pc: r_pc, ir: MEM_DOUT1, fault: 1'b0};
        w_flush     = BR_TAKEN;
        w_pop       = IF_VALID & IF_READY & ~BR_TAKEN;

        case (r_state)
            IDLE: begin
                if (!w_full && !r_halt) w_state_nxt = FETCH;
            end
            FETCH: begin
                if (w_out_of_range) begin
                    w_entry.ir    = NOP;
                    w_entry.fault = 1'b1;
                    w_push        = 1'b1;
                    w_halt_nxt    = 1'b1;
                    w_state_nxt   = IDLE;
                end else begin
                    MEM_RDEN1 = 1'b1;
                    if (memValid1) begin
                        w_push      = 1'b1;
                        w_pc_nxt    = r_pc + 32'd4;
                        w_state_nxt = w_last_slot ? IDLE : FETCH;
                    end
                end
            end
            SQUASH: begin
                MEM_RDEN1 = 1'b1;
                if (memValid1) w_state_nxt = FETCH;
            end
            default: w_state_nxt = IDLE;
        endcase

        // Redirect overrides push/pop; an outstanding miss is drained in SQUASH.
        if (BR_TAKEN) begin
            w_push     = 1'b0;
            w_pc_nxt   = BR_PC & ~32'h3;
            w_halt_nxt = 1'b0;
            if (r_state == SQUASH) begin
                w_state_nxt = memValid1 ? FETCH : SQUASH;
            end else if (MEM_RDEN1 && !memValid1) begin
                w_state_nxt = SQUASH;
                w_sq_load   = 1'b1;
            end else begin
                w_state_nxt = FETCH;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_pc    <= PC_RESET;
            r_halt  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_halt  <= w_halt_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_sq_load) r_sq_addr <= r_pc[15:2];
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_din   (w_entry),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

endmodule
